// File: rtl/latency_ram.sv
// Single-clock 32-bit RAM with one read port behind a configurable-latency
// register pipeline, a port-0 write port and a debug read/write port.
module latency_ram #(
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr_0,
  output logic [31:0] rdata_0,
  input  logic [31:0] waddr_0,
  input  logic        wen_0,
  input  logic [31:0] wdata_0,
  input  logic [31:0] debug_addr,
  output logic [31:0] debug_data,
  input  logic [31:0] debug_write_addr,
  input  logic [31:0] debug_write_data,
  input  logic        debug_write_en,
  output logic        err,
  output logic [15:0] wr_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem     [DEPTH];
  logic [31:0] rd_pipe [READ_LATENCY];

  logic raddr_ok;
  logic waddr_ok;
  logic dbg_raddr_ok;
  logic dbg_waddr_ok;
  logic dbg_commit;
  logic wr_commit;
  logic range_fault;

  // Full 32-bit compare so that addresses beyond DEPTH never alias into the array.
  assign raddr_ok     = raddr_0          < 32'(DEPTH);
  assign waddr_ok     = waddr_0          < 32'(DEPTH);
  assign dbg_raddr_ok = debug_addr       < 32'(DEPTH);
  assign dbg_waddr_ok = debug_write_addr < 32'(DEPTH);

  // The debug port owns an address when both ports hit it on the same edge.
  assign dbg_commit = !rst && debug_write_en && dbg_waddr_ok;
  assign wr_commit  = !rst && wen_0 && waddr_ok &&
                      !(dbg_commit && (debug_write_addr == waddr_0));

  assign range_fault = !raddr_ok || (wen_0 && !waddr_ok) ||
                       (debug_write_en && !dbg_waddr_ok);

  // NOTE: the array has no reset on purpose -- contents must survive rst, and
  // a resettable array would also stop it mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[waddr_0[AW-1:0]] <= wdata_0;
    end
    if (dbg_commit) begin
      mem[debug_write_addr[AW-1:0]] <= debug_write_data;
    end
  end

  // NOTE: non-blocking assignments make every stage and the array read sample
  // pre-edge values, which gives both the shift behaviour and read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= '0;
      end
      err      <= 1'b0;
      wr_count <= '0;
    end else begin
      rd_pipe[0] <= raddr_ok ? mem[raddr_0[AW-1:0]] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      if (range_fault) begin
        err <= 1'b1;
      end
      if (wr_commit && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  assign rdata_0    = rd_pipe[READ_LATENCY-1];
  assign debug_data = dbg_raddr_ok ? mem[debug_addr[AW-1:0]] : '0;

endmodule
